// File: rtl/scr1_tcm_dmem_bridge.sv
// Registered single-outstanding bridge between the core data port and scr1_tcm dmem.
// Adds real backpressure, misalignment rejection, a request timeout and an error counter.

package scr1_tcm_dmem_bridge_pkg;

    localparam int SCR1_DMEM_AWIDTH = 32;
    localparam int SCR1_DMEM_DWIDTH = 32;

    typedef enum logic {
        SCR1_MEM_CMD_RD = 1'b0,
        SCR1_MEM_CMD_WR = 1'b1
    } type_scr1_mem_cmd_e;

    typedef enum logic [1:0] {
        SCR1_MEM_WIDTH_BYTE  = 2'b00,
        SCR1_MEM_WIDTH_HWORD = 2'b01,
        SCR1_MEM_WIDTH_WORD  = 2'b10,
        SCR1_MEM_WIDTH_ERROR = 2'b11
    } type_scr1_mem_width_e;

    typedef enum logic [1:0] {
        SCR1_MEM_RESP_NOTRDY = 2'b00,
        SCR1_MEM_RESP_RDY_OK = 2'b01,
        SCR1_MEM_RESP_RDY_ER = 2'b10
    } type_scr1_mem_resp_e;

endpackage

module scr1_tcm_dmem_bridge
    import scr1_tcm_dmem_bridge_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 16,
    parameter int ERR_CNT_W      = 8
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        core_dmem_req,
    input  type_scr1_mem_cmd_e          core_dmem_cmd,
    input  type_scr1_mem_width_e        core_dmem_width,
    input  logic [SCR1_DMEM_AWIDTH-1:0] core_dmem_addr,
    input  logic [SCR1_DMEM_DWIDTH-1:0] core_dmem_wdata,
    output logic                        core_dmem_req_ack,
    output logic [SCR1_DMEM_DWIDTH-1:0] core_dmem_rdata,
    output type_scr1_mem_resp_e         core_dmem_resp,
    output logic                        tcm_dmem_req,
    output type_scr1_mem_cmd_e          tcm_dmem_cmd,
    output type_scr1_mem_width_e        tcm_dmem_width,
    output logic [SCR1_DMEM_AWIDTH-1:0] tcm_dmem_addr,
    output logic [SCR1_DMEM_DWIDTH-1:0] tcm_dmem_wdata,
    input  logic                        tcm_dmem_req_ack,
    input  logic [SCR1_DMEM_DWIDTH-1:0] tcm_dmem_rdata,
    input  type_scr1_mem_resp_e         tcm_dmem_resp,
    output logic                        busy,
    output logic [ERR_CNT_W-1:0]        err_cnt
);

    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT_CYCLES - 1);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_REQ  = 2'd1;
    localparam logic [1:0] ST_WAIT = 2'd2;
    localparam logic [1:0] ST_RESP = 2'd3;

    logic [1:0]                  state;
    logic [TW-1:0]               timer;
    type_scr1_mem_resp_e         resp_q;
    logic [SCR1_DMEM_DWIDTH-1:0] rdata_q;
    logic                        misaligned;
    logic                        new_req;
    logic                        timeout;
    logic                        err_event;

    // Alignment check on the incoming core request
    always_comb begin
        misaligned = 1'b0;
        case (core_dmem_width)
            SCR1_MEM_WIDTH_HWORD: misaligned = core_dmem_addr[0];
            SCR1_MEM_WIDTH_WORD:  misaligned = |core_dmem_addr[1:0];
            default:              misaligned = 1'b0;
        endcase
    end

    // Handshake and error event decode
    always_comb begin
        new_req   = (state == ST_IDLE) & core_dmem_req;
        timeout   = (state == ST_REQ) & ~tcm_dmem_req_ack
                  & (timer == TIMER_LAST);
        err_event = (new_req & misaligned) | timeout;
    end

    assign core_dmem_req_ack = (state == ST_IDLE);
    assign busy              = (state != ST_IDLE);
    assign core_dmem_resp    = (state == ST_RESP) ? resp_q
                                                  : SCR1_MEM_RESP_NOTRDY;
    assign core_dmem_rdata   = (state == ST_RESP) ? rdata_q : '0;

    // Main FSM: request capture, downstream handshake, response staging
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state          <= ST_IDLE;
            timer          <= '0;
            tcm_dmem_req   <= 1'b0;
            tcm_dmem_cmd   <= SCR1_MEM_CMD_RD;
            tcm_dmem_width <= SCR1_MEM_WIDTH_BYTE;
            tcm_dmem_addr  <= '0;
            tcm_dmem_wdata <= '0;
            resp_q         <= SCR1_MEM_RESP_NOTRDY;
            rdata_q        <= '0;
        end else begin
            unique case (state)
                ST_IDLE: begin
                    if (new_req) begin
                        if (misaligned) begin
                            resp_q  <= SCR1_MEM_RESP_RDY_ER;
                            rdata_q <= '0;
                            state   <= ST_RESP;
                        end else begin
                            tcm_dmem_req   <= 1'b1;
                            tcm_dmem_cmd   <= core_dmem_cmd;
                            tcm_dmem_width <= core_dmem_width;
                            tcm_dmem_addr  <= core_dmem_addr;
                            tcm_dmem_wdata <= core_dmem_wdata;
                            timer          <= '0;
                            state          <= ST_REQ;
                        end
                    end
                end
                ST_REQ: begin
                    // A late ack still beats the timeout on the same cycle
                    if (tcm_dmem_req_ack) begin
                        tcm_dmem_req <= 1'b0;
                        state        <= ST_WAIT;
                    end else if (timeout) begin
                        tcm_dmem_req <= 1'b0;
                        resp_q       <= SCR1_MEM_RESP_RDY_ER;
                        rdata_q      <= '0;
                        state        <= ST_RESP;
                    end else begin
                        timer <= timer + 1'b1;
                    end
                end
                ST_WAIT: begin
                    if (tcm_dmem_resp != SCR1_MEM_RESP_NOTRDY) begin
                        resp_q  <= tcm_dmem_resp;
                        rdata_q <= tcm_dmem_rdata;
                        state   <= ST_RESP;
                    end
                end
                ST_RESP: begin
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    // Saturating error counter for misalign and timeout events
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_cnt <= '0;
        end else if (err_event && (err_cnt != {ERR_CNT_W{1'b1}})) begin
            err_cnt <= err_cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_scr1_tcm_dmem_bridge.sv
// Directed scoreboard bench for scr1_tcm_dmem_bridge.
// Small TCM model with programmable ack/response delay.

module tb_scr1_tcm_dmem_bridge;
    import scr1_tcm_dmem_bridge_pkg::*;

    localparam int TO = 4;
    localparam int EW = 2;

    typedef struct {
        type_scr1_mem_resp_e resp;
        logic [31:0]         rdata;
    } exp_t;

    logic                 clk = 1'b0;
    logic                 rst;
    logic                 core_dmem_req;
    type_scr1_mem_cmd_e   core_dmem_cmd;
    type_scr1_mem_width_e core_dmem_width;
    logic [31:0]          core_dmem_addr;
    logic [31:0]          core_dmem_wdata;
    logic                 core_dmem_req_ack;
    logic [31:0]          core_dmem_rdata;
    type_scr1_mem_resp_e  core_dmem_resp;
    logic                 tcm_dmem_req;
    type_scr1_mem_cmd_e   tcm_dmem_cmd;
    type_scr1_mem_width_e tcm_dmem_width;
    logic [31:0]          tcm_dmem_addr;
    logic [31:0]          tcm_dmem_wdata;
    logic                 tcm_dmem_req_ack;
    logic [31:0]          tcm_dmem_rdata;
    type_scr1_mem_resp_e  tcm_dmem_resp;
    logic                 busy;
    logic [EW-1:0]        err_cnt;

    scr1_tcm_dmem_bridge #(
        .TIMEOUT_CYCLES(TO),
        .ERR_CNT_W     (EW)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .core_dmem_req    (core_dmem_req),
        .core_dmem_cmd    (core_dmem_cmd),
        .core_dmem_width  (core_dmem_width),
        .core_dmem_addr   (core_dmem_addr),
        .core_dmem_wdata  (core_dmem_wdata),
        .core_dmem_req_ack(core_dmem_req_ack),
        .core_dmem_rdata  (core_dmem_rdata),
        .core_dmem_resp   (core_dmem_resp),
        .tcm_dmem_req     (tcm_dmem_req),
        .tcm_dmem_cmd     (tcm_dmem_cmd),
        .tcm_dmem_width   (tcm_dmem_width),
        .tcm_dmem_addr    (tcm_dmem_addr),
        .tcm_dmem_wdata   (tcm_dmem_wdata),
        .tcm_dmem_req_ack (tcm_dmem_req_ack),
        .tcm_dmem_rdata   (tcm_dmem_rdata),
        .tcm_dmem_resp    (tcm_dmem_resp),
        .busy             (busy),
        .err_cnt          (err_cnt)
    );

    always #5 clk = ~clk;

    // TCM model controls
    logic                ack_en;
    int                  ack_delay;
    int                  resp_delay;
    type_scr1_mem_resp_e resp_code;

    int          req_age = 0;
    logic        pend    = 1'b0;
    int          dly     = 0;
    logic [31:0] rd_lat  = '0;

    function automatic logic [31:0] tcm_data(input logic [31:0] a);
        return (a == 32'h0048_0010) ? 32'hDEAD_BEEF : (a ^ 32'h5A5A_5A5A);
    endfunction

    assign tcm_dmem_req_ack = tcm_dmem_req & ack_en & (req_age >= ack_delay);
    assign tcm_dmem_resp    = (pend && dly == 0) ? resp_code
                                                 : SCR1_MEM_RESP_NOTRDY;
    assign tcm_dmem_rdata   = (pend && dly == 0) ? rd_lat : '0;

    // TCM model state
    always @(posedge clk) begin
        if (tcm_dmem_req && !tcm_dmem_req_ack) req_age <= req_age + 1;
        else                                   req_age <= 0;
        if (tcm_dmem_req && tcm_dmem_req_ack) begin
            pend   <= 1'b1;
            dly    <= resp_delay;
            rd_lat <= tcm_data(tcm_dmem_addr);
        end else if (pend && dly != 0) begin
            dly <= dly - 1;
        end else if (pend) begin
            pend <= 1'b0;
        end
    end

    int   total = 0;
    int   bad   = 0;
    int   req_hi = 0;
    int   nresp  = 0;
    exp_t sb[$];
    logic [66:0] exp_fields = '0;

    task automatic chk(input string tag, input logic [95:0] obs,
                       input logic [95:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        exp_t e;
        @(posedge clk);
        #1;
        if (tcm_dmem_req) begin
            req_hi++;
            chk("tcm_fields", {tcm_dmem_cmd, tcm_dmem_width, tcm_dmem_addr,
                               tcm_dmem_wdata}, exp_fields);
        end
        if (core_dmem_resp != SCR1_MEM_RESP_NOTRDY) begin
            if (sb.size() == 0) begin
                chk("unexp_resp", core_dmem_resp, SCR1_MEM_RESP_NOTRDY);
            end else begin
                e = sb.pop_front();
                nresp++;
                chk("resp", core_dmem_resp, e.resp);
                chk("rdata", core_dmem_rdata, e.rdata);
            end
        end
    endtask

    task automatic issue(input type_scr1_mem_cmd_e c,
                         input type_scr1_mem_width_e w,
                         input logic [31:0] a, input logic [31:0] d,
                         input type_scr1_mem_resp_e er,
                         input logic [31:0] ed, output int waited);
        exp_t e;
        logic mis;
        core_dmem_req   = 1'b1;
        core_dmem_cmd   = c;
        core_dmem_width = w;
        core_dmem_addr  = a;
        core_dmem_wdata = d;
        waited = 0;
        #1;
        while (!core_dmem_req_ack && waited < 40) begin
            step();
            #1;
            waited++;
        end
        chk("req_ack", core_dmem_req_ack, 1'b1);
        mis = (w == SCR1_MEM_WIDTH_HWORD && a[0]) ||
              (w == SCR1_MEM_WIDTH_WORD && a[1:0] != 2'b00);
        if (!mis) exp_fields = {c, w, a, d};
        e.resp  = er;
        e.rdata = ed;
        sb.push_back(e);
        step();
    endtask

    task automatic wait_done(output int n);
        n = 0;
        while (sb.size() != 0 && n < 40) begin
            step();
            n++;
        end
        chk("sb_drain", sb.size(), 0);
    endtask

    initial begin
        int w;
        int n;
        int r0;
        int k0;
        rst             = 1'b1;
        core_dmem_req   = 1'b0;
        core_dmem_cmd   = SCR1_MEM_CMD_RD;
        core_dmem_width = SCR1_MEM_WIDTH_BYTE;
        core_dmem_addr  = '0;
        core_dmem_wdata = '0;
        ack_en          = 1'b1;
        ack_delay       = 0;
        resp_delay      = 0;
        resp_code       = SCR1_MEM_RESP_RDY_OK;
        step();
        step();
        chk("rst_tcm", {tcm_dmem_req, tcm_dmem_cmd, tcm_dmem_width,
                        tcm_dmem_addr, tcm_dmem_wdata}, '0);
        chk("rst_resp", {core_dmem_resp, core_dmem_rdata}, '0);
        chk("rst_err", err_cnt, 0);
        chk("rst_busy", busy, 0);
        rst = 1'b0;
        step();

        // Aligned read, immediate ack, 1-cycle TCM response
        issue(SCR1_MEM_CMD_RD, SCR1_MEM_WIDTH_WORD, 32'h0048_0010, 32'h0,
              SCR1_MEM_RESP_RDY_OK, 32'hDEAD_BEEF, w);
        core_dmem_req = 1'b0;
        wait_done(n);
        chk("lat_aligned", n, 2);
        chk("err_t1", err_cnt, 0);
        step();

        // Misaligned accesses are rejected locally
        r0 = req_hi;
        issue(SCR1_MEM_CMD_WR, SCR1_MEM_WIDTH_WORD, 32'h0048_0002, 32'h1234,
              SCR1_MEM_RESP_RDY_ER, 32'h0, w);
        core_dmem_req = 1'b0;
        wait_done(n);
        chk("lat_mis", n, 0);
        chk("err_t2a", err_cnt, 1);
        step();
        issue(SCR1_MEM_CMD_RD, SCR1_MEM_WIDTH_HWORD, 32'h0048_0001, 32'h0,
              SCR1_MEM_RESP_RDY_ER, 32'h0, w);
        core_dmem_req = 1'b0;
        wait_done(n);
        chk("err_t2b", err_cnt, 2);
        chk("mis_no_fwd", req_hi - r0, 0);
        step();

        // Ack on the last timeout cycle still wins
        ack_delay = TO - 1;
        issue(SCR1_MEM_CMD_WR, SCR1_MEM_WIDTH_HWORD, 32'h0048_0106,
              32'hCAFE_F00D, SCR1_MEM_RESP_RDY_OK,
              tcm_data(32'h0048_0106), w);
        core_dmem_req = 1'b0;
        wait_done(n);
        chk("lat_late_ack", n, 5);
        chk("err_t4", err_cnt, 2);
        step();

        // No ack at all: timeout
        ack_en = 1'b0;
        r0 = req_hi;
        issue(SCR1_MEM_CMD_RD, SCR1_MEM_WIDTH_BYTE, 32'h0048_0203, 32'h0,
              SCR1_MEM_RESP_RDY_ER, 32'h0, w);
        core_dmem_req = 1'b0;
        wait_done(n);
        chk("to_req_cycles", req_hi - r0, TO);
        chk("lat_timeout", n, TO);
        chk("err_t3", err_cnt, 3);
        ack_en    = 1'b1;
        ack_delay = 0;
        step();

        // Back-to-back with the request held high
        k0 = nresp;
        issue(SCR1_MEM_CMD_RD, SCR1_MEM_WIDTH_WORD, 32'h0048_0400, 32'h0,
              SCR1_MEM_RESP_RDY_OK, tcm_data(32'h0048_0400), w);
        issue(SCR1_MEM_CMD_WR, SCR1_MEM_WIDTH_WORD, 32'h0048_0404, 32'h77,
              SCR1_MEM_RESP_RDY_OK, tcm_data(32'h0048_0404), w);
        chk("b2b_gap1", w, 3);
        issue(SCR1_MEM_CMD_RD, SCR1_MEM_WIDTH_HWORD, 32'h0048_0408, 32'h0,
              SCR1_MEM_RESP_RDY_OK, tcm_data(32'h0048_0408), w);
        chk("b2b_gap2", w, 3);
        core_dmem_req = 1'b0;
        wait_done(n);
        chk("b2b_nresp", nresp - k0, 3);
        step();

        // Reset while waiting for a delayed TCM response
        resp_delay = 3;
        issue(SCR1_MEM_CMD_RD, SCR1_MEM_WIDTH_WORD, 32'h0048_0500, 32'h0,
              SCR1_MEM_RESP_RDY_OK, tcm_data(32'h0048_0500), w);
        core_dmem_req = 1'b0;
        step();
        chk("pre_rst_busy", busy, 1);
        rst = 1'b1;
        sb.delete();
        for (int i = 0; i < 4; i++) begin
            step();
            chk("mid_rst_tcm", {tcm_dmem_req, tcm_dmem_addr}, '0);
            chk("mid_rst_resp", {core_dmem_resp, core_dmem_rdata}, '0);
        end
        chk("mid_rst_err", err_cnt, 0);
        rst        = 1'b0;
        resp_delay = 0;
        k0 = nresp;
        for (int i = 0; i < 4; i++) step();
        chk("post_rst_nresp", nresp - k0, 0);
        chk("post_rst_busy", busy, 0);

        // Saturation of the 2-bit error counter
        for (int i = 1; i <= 5; i++) begin
            issue(SCR1_MEM_CMD_RD, SCR1_MEM_WIDTH_WORD, 32'h0048_0601, 32'h0,
                  SCR1_MEM_RESP_RDY_ER, 32'h0, w);
            core_dmem_req = 1'b0;
            wait_done(n);
            chk("err_sat", err_cnt, (i > 3) ? 3 : i);
            step();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
